// File: rtl/sd_wb_ram.sv
// sd_wb_ram: Wishbone B3 slave RAM terminating the SD core's master port.
// Serves classic single beats and linear incrementing bursts (cti=010, bte=00)
// with WAIT programmable wait states; out-of-window or misaligned beats are
// terminated with err and never touch the array.
//
// Ports:
//   clk_50, reset_n          clock, asynchronous active-low reset
//   wbs_adr_i/dat_i/sel_i    byte address, write data, byte lanes
//   wbs_cyc_i/stb_i/we_i     Wishbone qualifiers
//   wbs_cti_i/bte_i          cycle type / burst type
//   wbs_dat_o/ack_o/err_o    registered read data, acknowledge, error
//   stat_rd_beats/wr_beats   acked read / write beat counters
//
// Optional feature: define SD_WB_RAM_STATS_EN to build the beat counters;
// otherwise both stat ports are tied to zero.
module sd_wb_ram #(
    parameter int unsigned MEM_AW    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WAIT      = 0
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] stat_rd_beats,
    output logic [31:0] stat_wr_beats
);

    localparam int unsigned DEPTH = 2 ** MEM_AW;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BEAT} state_t;

    state_t              state;
    logic [31:0]         mem [DEPTH];
    // Extra top bit marks a burst that has run past the last word.
    logic [MEM_AW:0]     beat_idx;
    logic                oor_q;
    logic                burst_q;
    logic                we_q;
    logic [1:0]          wait_cnt;

    logic                req_c;
    logic                req_oor_c;
    logic                req_burst_c;
    logic [MEM_AW:0]     req_idx_c;
    logic [MEM_AW:0]     next_idx_c;
    logic                acked_c;
    logic                cont_c;
    logic                launch_c;
    logic [MEM_AW:0]     launch_idx_c;
    logic                launch_oor_c;
    logic [31:0]         rd_data_c;

    // Request decode and selection of the beat launched at the next edge.
    always_comb begin
        req_c        = wbs_cyc_i & wbs_stb_i;
        req_idx_c    = {1'b0, wbs_adr_i[MEM_AW+1:2]};
        // Base is aligned to the window size, so range is an upper-bit match.
        req_oor_c    = (wbs_adr_i[31:MEM_AW+2] != BASE_ADDR[31:MEM_AW+2]) |
                       (wbs_adr_i[1:0] != 2'b00);
        req_burst_c  = (wbs_cti_i == 3'b010) & (wbs_bte_i == 2'b00);
        next_idx_c   = beat_idx + (MEM_AW+1)'(1);
        acked_c      = (state == ST_BEAT) & wbs_ack_o & req_c;
        cont_c       = acked_c & burst_q & (wbs_cti_i != 3'b111);
        launch_c     = 1'b0;
        launch_idx_c = beat_idx;
        launch_oor_c = oor_q;
        case (state)
            ST_IDLE: begin
                if (req_c && (WAIT == 0)) begin
                    launch_c     = 1'b1;
                    launch_idx_c = req_idx_c;
                    launch_oor_c = req_oor_c;
                end
            end
            ST_WAIT: begin
                if (wbs_cyc_i && (wait_cnt == 2'd0)) begin
                    launch_c = 1'b1;
                end
            end
            ST_BEAT: begin
                if (cont_c) begin
                    launch_c     = 1'b1;
                    launch_idx_c = next_idx_c;
                    launch_oor_c = oor_q | next_idx_c[MEM_AW];
                end
            end
            default: ;
        endcase
        rd_data_c = mem[launch_idx_c[MEM_AW-1:0]];
    end

    // Access FSM with registered ack/err/dat_o.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            beat_idx  <= '0;
            oor_q     <= 1'b0;
            burst_q   <= 1'b0;
            we_q      <= 1'b0;
            wait_cnt  <= 2'd0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            if (launch_c) begin
                wbs_ack_o <= ~launch_oor_c;
                wbs_err_o <= launch_oor_c;
                wbs_dat_o <= launch_oor_c ? 32'h0 : rd_data_c;
            end
            case (state)
                ST_IDLE: begin
                    if (req_c) begin
                        beat_idx <= req_idx_c;
                        oor_q    <= req_oor_c;
                        burst_q  <= req_burst_c;
                        we_q     <= wbs_we_i;
                        if (WAIT == 0) begin
                            state <= ST_BEAT;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= 2'(WAIT - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == 2'd0) begin
                        state <= ST_BEAT;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_BEAT: begin
                    if (cont_c) begin
                        beat_idx <= next_idx_c;
                        oor_q    <= launch_oor_c;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Array write port: byte-lane commit at the acked write edge.
    always_ff @(posedge clk_50) begin
        if (acked_c && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b]) begin
                    mem[beat_idx[MEM_AW-1:0]][b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
                end
            end
        end
    end

`ifdef SD_WB_RAM_STATS_EN
    // Acked beat counters, free-running with natural wrap.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            stat_rd_beats <= 32'h0;
            stat_wr_beats <= 32'h0;
        end else if (acked_c) begin
            if (we_q) begin
                stat_wr_beats <= stat_wr_beats + 32'd1;
            end else begin
                stat_rd_beats <= stat_rd_beats + 32'd1;
            end
        end
    end
`else
    assign stat_rd_beats = 32'h0;
    assign stat_wr_beats = 32'h0;
`endif

endmodule

// File: doc/sd_wb_ram.md
# sd_wb_ram

Wishbone B3 slave RAM that terminates the SD device core's wishbone master port. It lets the complete card emulation run on-chip for bring-up and regression without an external memory controller. It accepts the core's classic and linear incrementing-burst cycles, inserts programmable wait states, and flags out-of-window accesses with `err`. It sits directly downstream of `sd_top` on the same 50 MHz domain.

## Interface
- `MEM_AW`, 14: word-address bits; the array holds 2^MEM_AW 32-bit words (64 KiB by default).
- `BASE_ADDR`, 32'h0000_0000: byte base of the window. Must be aligned to 4·2^MEM_AW.
- `WAIT`, 0: wait states (0..3) inserted before the first beat of each access.
- `clk_50` in 1: system clock, shared with `sd_top`.
- `reset_n` in 1: asynchronous, active-low reset.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_dat_o` out 32: read data, valid only while `wbs_ack_o` is high.
- `wbs_sel_i` in 4: byte lanes; bit n selects byte n.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1 each: standard Wishbone qualifiers.
- `wbs_cti_i` in 3 / `wbs_bte_i` in 2: cycle type and burst type.
- `wbs_ack_o` out 1: beat acknowledge (registered).
- `wbs_err_o` out 1: error terminate (registered).
- `stat_rd_beats` out 32: count of acked read beats.
- `stat_wr_beats` out 32: count of acked write beats.

## Operation
- Reset values: `wbs_ack_o`=0, `wbs_err_o`=0, `wbs_dat_o`=0, stat counters=0, state=IDLE. Reset does not clear array contents.
- A request is `wbs_cyc_i & wbs_stb_i`.
- In range means `BASE_ADDR <= adr < BASE_ADDR + 4·2^MEM_AW` and `adr[1:0]==0`. Word index = `(adr-BASE_ADDR)[MEM_AW+1:2]`.
- FSM states:
  - IDLE: on a request, latch the word index, `we`, and burst mode into the beat-address counter. Burst mode = (`cti==3'b010` and `bte==2'b00`); any other cti/bte combination is served as a classic single beat. Go to WAIT if `WAIT`>0, else to BEAT.
  - WAIT: count down `WAIT` cycles, then go to BEAT. If `cyc` drops, return to IDLE.
  - BEAT: assert `ack` (or `err` if the beat is out of range) for exactly one cycle per beat.
    - At an edge with `ack & stb` and burst mode and `cti!=3'b111`: stay in BEAT, increment the beat counter, keep `ack` high.
    - Otherwise: go to IDLE. `ack` is low for at least one cycle.
- Writes commit at the edge where `ack & stb & we`. Each lane with `sel[n]=1` writes byte n of `dat_i`; other lanes are preserved.
- Reads: `dat_o` is registered from `mem[beat counter]` in the same cycle `ack` is driven. In a burst, the next word is fetched at the acked edge, so consecutive beats need no bubbles.
- Error path: an out-of-range beat raises `err`, does no write, returns `dat_o`=0, and ends the access (state goes to IDLE). A burst that runs past the top of the array errs on the first beat beyond it; there is no wrap.
- `cyc` deasserted in any state: go to IDLE on the next edge, drop `ack`/`err`, perform no further writes.
- Master address changes during a burst are ignored; only the internal counter addresses the array.

## Timing
- Request first seen at edge N: first `ack` is high in cycle N+1+WAIT.
- Burst throughput: 1 beat per cycle.
- Classic throughput: 1 beat per 2+WAIT cycles.
- `ack` and `err` are never high together.
- Back-to-back classic requests: `stb` still high in the cycle after IDLE is re-entered is taken as a new request.
- Counter updates happen at the acked edge. Counters wrap at 2^32.

## Configuration
- `SD_WB_RAM_STATS_EN`:
  - Defined: `stat_rd_beats` and `stat_wr_beats` count acked (non-err) beats.
  - Undefined: both ports are tied to 32'h0 and no counter flops are built.

## Test plan
- Reset, then classic write of 32'hDEADBEEF to 0x10 (sel=4'hF) followed by a classic read of 0x10: read returns DEADBEEF; with WAIT=0, `ack` arrives 1 cycle after `stb`.
- WAIT=2, classic read of 0x0: `ack` arrives 3 cycles after `stb`. Drop `cyc` during the wait: no `ack`, FSM returns to IDLE.
- 8-beat linear read burst from 0x100 (cti=010, final beat cti=111): 8 consecutive `ack` cycles with data = mem[0x40..0x47], then `ack` low.
- Partial write sel=4'b0101 of 32'h11223344 over 32'hAAAAAAAA: readback gives 32'hAA22AA44.
- Access at BASE_ADDR+0x10000 with MEM_AW=14, and at a misaligned address 0x2: `err`=1, `ack`=0, no array change. A burst starting at the last word gives `ack` then `err`.
- Assert `reset_n` low mid-burst: `ack`, `err`, and `dat_o` go to 0 immediately. After release, previously written data is intact. With `SD_WB_RAM_STATS_EN` defined, counters read 0 after reset and 8 reads after the test-3 burst.
